// File: rtl/timer_pkg.sv
// Shared types and helpers for the seconds timer arbiter and its prescaler.
package timer_pkg;

    localparam int DEFAULT_CLK_HZ = 100_000_000;

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} timer_state_e;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..CLK_HZ-1 counter producing a one-cycle tick on wrap.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CNT_W = clog2(CLK_HZ);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (enable)
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end

    assign tick = enable && (cnt == CNT_MAX);

endmodule

// File: rtl/seconds_timer_arbiter.sv
// Round-robin shared seconds countdown timer. Define SECONDS_TIMER_PAUSE_EN
// to add a pause input that freezes the countdown while in COUNT.
module seconds_timer_arbiter
    import timer_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int N_REQ  = 4,
    parameter int SEC_W  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef SECONDS_TIMER_PAUSE_EN
    input  logic                   pause,
`endif
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*SEC_W-1:0] req_secs,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [SEC_W-1:0]       remaining,
    output logic                   tick
);
    localparam int IDX_W = clog2(N_REQ);

    timer_state_e     state;
    logic [IDX_W-1:0] ptr, win, rr_win, nxt_ptr;
    logic [SEC_W-1:0] win_secs;
    logic             count_en;

    // First requester at or after ptr; descending scan so the nearest one wins.
    always_comb begin
        rr_win = ptr;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N_REQ])
                rr_win = IDX_W'((int'(ptr) + k) % N_REQ);
    end

    assign nxt_ptr  = (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    assign win_secs = req_secs[win*SEC_W +: SEC_W];

`ifdef SECONDS_TIMER_PAUSE_EN
    assign count_en = (state == COUNT) && !pause;
`else
    assign count_en = (state == COUNT);
`endif

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == LOAD),
        .enable (count_en),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            remaining <= '0;
            ptr       <= '0;
            win       <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: if (|req) begin
                    state <= LOAD;
                    win   <= rr_win;
                    grant <= N_REQ'(1) << rr_win;
                    busy  <= 1'b1;
                end
                LOAD, COUNT: begin
                    if (!req[win]) begin
                        // Owner withdrew: release without a done pulse.
                        state     <= IDLE;
                        grant     <= '0;
                        busy      <= 1'b0;
                        remaining <= '0;
                        ptr       <= nxt_ptr;
                    end else if (state == LOAD) begin
                        remaining <= win_secs;
                        if (win_secs == '0) begin
                            state <= DONE;
                            done  <= grant;
                        end else begin
                            state <= COUNT;
                        end
                    end else if (tick && remaining != '0) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == SEC_W'(1)) begin
                            state <= DONE;
                            done  <= grant;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    ptr   <= nxt_ptr;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seconds_timer_arbiter.sv
// Bench for seconds_timer_arbiter at CLK_HZ=10: vector table plus corner sequences.
module tb_seconds_timer_arbiter;
    localparam int CLK_HZ = 10;
    localparam int N_REQ  = 4;
    localparam int SEC_W  = 6;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*SEC_W-1:0] req_secs;
    logic [N_REQ-1:0]       grant, done;
    logic                   busy, tick;
    logic [SEC_W-1:0]       remaining;
`ifdef SECONDS_TIMER_PAUSE_EN
    logic                   pause = 1'b0;
`endif

    seconds_timer_arbiter #(.CLK_HZ(CLK_HZ), .N_REQ(N_REQ), .SEC_W(SEC_W)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef SECONDS_TIMER_PAUSE_EN
        .pause     (pause),
`endif
        .req       (req),
        .req_secs  (req_secs),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .remaining (remaining),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [N_REQ-1:0] mask; } exp_t;
    typedef struct { int idx; int secs; int ticks; } vec_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc = 0, checks = 0, errors = 0, done_seen = 0, tick_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each done pulse must match the oldest expected (cycle, mask).
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (tick) tick_cnt++;
            if (done != '0) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got %b expected none (cycle %0d)", done, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_mask", 32'(done), 32'(e.mask));
                end
                done_seen++;
            end
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wait_done(input int target, input int limit);
        int n = 0;
        while (done_seen < target && n < limit) begin step(); n++; end
        if (done_seen < target) begin
            checks++; errors++;
            $display("FAIL wait_done_timeout: got %0d pulses expected %0d", done_seen, target);
        end
    endtask

    task automatic set_secs(input int idx, input int secs);
        req_secs[idx*SEC_W +: SEC_W] = SEC_W'(secs);
    endtask

    vec_t vecs[4];
    int   c, n, k;
    logic [N_REQ-1:0] order [3];
    logic [N_REQ-1:0] prev;

    initial begin
        vecs[0] = '{idx: 2, secs: 3, ticks: 3};
        vecs[1] = '{idx: 1, secs: 0, ticks: 0};
        vecs[2] = '{idx: 0, secs: 2, ticks: 2};
        vecs[3] = '{idx: 3, secs: 1, ticks: 1};

        reset = 1'b1; req = '0; req_secs = '0;
        step(); step();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_remaining", 32'(remaining), 0);
        chk("rst_tick", 32'(tick), 0);
        reset = 1'b0;
        step();

        // Single-requester vectors; last one (idx 3) leaves the pointer at 0.
        for (int v = 0; v < 4; v++) begin
            set_secs(vecs[v].idx, vecs[v].secs);
            req[vecs[v].idx] = 1'b1;
            c = cyc;
            exp_q.push_back('{cyc: c + 2 + vecs[v].secs * CLK_HZ, mask: N_REQ'(1) << vecs[v].idx});
            tick_cnt = 0;
            k = done_seen;
            step();
            chk("vec_grant", 32'(grant), 32'(N_REQ'(1) << vecs[v].idx));
            chk("vec_busy", 32'(busy), 1);
            step();
            chk("vec_remaining_load", 32'(remaining), 32'(vecs[v].secs));
            if (vecs[v].secs == 3) begin
                while (cyc < c + 12) step();
                chk("vec_remaining_after_tick1", 32'(remaining), 2);
            end
            wait_done(k + 1, 100);
            req = '0;
            step();
            chk("vec_grant_release", 32'(grant), 0);
            chk("vec_busy_release", 32'(busy), 0);
            chk("vec_ticks", 32'(tick_cnt), 32'(vecs[v].ticks));
        end

        // Round-robin among 0,1,3 with secs=1; owners drop req on their done.
        step();
        set_secs(0, 1); set_secs(1, 1); set_secs(3, 1);
        req = 4'b1011;
        c = cyc;
        exp_q.push_back('{cyc: c + 12, mask: 4'b0001});
        exp_q.push_back('{cyc: c + 25, mask: 4'b0010});
        exp_q.push_back('{cyc: c + 38, mask: 4'b1000});
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b1000;
        k = 0; prev = '0; n = 0;
        while (req != '0 && n < 100) begin
            step(); n++;
            if (grant != '0 && grant != prev && k < 3) begin
                chk("rr_grant_order", 32'(grant), 32'(order[k]));
                k++;
            end
            prev = grant;
            req = req & ~done;
        end
        chk("rr_grant_count", k, 3);

        // Pointer back at 0: req 0 and 3 together with secs=0, 0 wins then 3 back-to-back.
        step(); step();
        set_secs(0, 0); set_secs(3, 0);
        req = 4'b1001;
        c = cyc;
        exp_q.push_back('{cyc: c + 2, mask: 4'b0001});
        exp_q.push_back('{cyc: c + 5, mask: 4'b1000});
        k = done_seen;
        step();
        chk("ptr_wrap_grant", 32'(grant), 32'(4'b0001));
        wait_done(k + 1, 20);
        req[0] = 1'b0;
        step();
        chk("b2b_idle_gap", 32'(grant), 0);
        wait_done(k + 2, 20);
        req = '0;
        step(); step();

        // Abort: req0 secs=5 dropped after 2 ticks, pending req1 (secs=0) served next.
        set_secs(0, 5); set_secs(1, 0);
        req = 4'b0011;
        c = cyc;
        tick_cnt = 0;
        n = 0;
        while (tick_cnt < 2 && n < 60) begin step(); n++; end
        chk("abort_tick2_cycle", cyc, c + 21);
        chk("abort_remaining", 32'(remaining), 4);
        req[0] = 1'b0;
        exp_q.push_back('{cyc: c + 24, mask: 4'b0010});
        k = done_seen;
        step();
        chk("abort_grant", 32'(grant), 0);
        chk("abort_busy", 32'(busy), 0);
        step();
        chk("abort_next_grant", 32'(grant), 32'(4'b0010));
        wait_done(k + 1, 20);
        req = '0;
        step(); step();

        // Reset mid-COUNT at remaining=4, then full re-run of secs=6.
        set_secs(2, 6);
        req = 4'b0100;
        n = 0;
        while (remaining != 4 && n < 60) begin step(); n++; end
        chk("rst_mid_remaining", 32'(remaining), 4);
        reset = 1'b1;
        step();
        chk("rst_mid_grant", 32'(grant), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_remaining0", 32'(remaining), 0);
        chk("rst_mid_tick", 32'(tick), 0);
        chk("rst_mid_done", 32'(done), 0);
        reset = 1'b0;
        c = cyc;
        exp_q.push_back('{cyc: c + 2 + 6 * CLK_HZ, mask: 4'b0100});
        k = done_seen;
        wait_done(k + 1, 100);
        req = '0;
        step(); step();

`ifdef SECONDS_TIMER_PAUSE_EN
        // Pause 25 cycles in COUNT: done 25 cycles later than the unpaused t+22.
        set_secs(1, 2);
        req = 4'b0010;
        c = cyc;
        exp_q.push_back('{cyc: c + 2 + 2 * CLK_HZ + 25, mask: 4'b0010});
        tick_cnt = 0;
        k = done_seen;
        while (cyc < c + 5) step();
        pause = 1'b1;
        while (cyc < c + 30) step();
        pause = 1'b0;
        wait_done(k + 1, 100);
        req = '0;
        step();
        chk("pause_ticks", 32'(tick_cnt), 2);
`endif

        step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
